hps_led_driver: RTL and testbench
=================================

# hps_led_driver

- Output stage between the HPS LED PIO and the board LED pins.
- Takes the 7-bit LED pattern from the PIO's `out_port` and drives the physical LEDs with:
  - global PWM brightness,
  - optional blinking,
  - optional polarity inversion.
- Has its own small Avalon-MM slave register file, in the same style as the PIO: zero-wait-state writes and combinational `readdata`.

## Interface
Parameters:
- `LED_W`, 7: LED count; must match the PIO width.
- `PWM_W`, 8: duty resolution; the PWM frame is 2^PWM_W−1 = 255 cycles.
- `BLINK_W`, 16: blink-period counter width, counted in PWM frames.

Ports:
- `clk`  in  1  single system clock; all logic is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `led_pattern`  in  LED_W  pattern from the PIO; synchronous to `clk`.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read data; zero-extended.
- `led_out`  out  LED_W  registered LED pin drive.

## Operation
Registers (unlisted bits read as 0; writes to unlisted bits are ignored):
- addr 0 `CTRL`, reset value 0x1.
  - bit0 `enable`.
  - bit1 `blink_en`.
  - bit2 `invert`: pins are active-low when set.
- addr 1 `DUTY[PWM_W-1:0]`, reset value 0xFF.
- addr 2 `BLINK_PERIOD[BLINK_W-1:0]`, reset value 0.
- addr 3 `STATUS`, read-only.
  - bit0 `blink_phase`.
  - bits[15:8] current `pwm_cnt`.
  - Writes to addr 3 are ignored.

Write rule:
- A write happens on a `clk` edge when `chipselect && !write_n`.
- `CTRL` takes effect on the next cycle.
- `DUTY` goes to a shadow register and is applied at the next frame boundary.
- Writing `BLINK_PERIOD` clears `blink_cnt` to 0 and sets `blink_phase` to 1.

PWM time base:
- `pwm_cnt` counts 0..254, then wraps to 0.
- `frame_tick` = (`pwm_cnt` == 254).
- On `frame_tick`:
  - `pattern_q` ← `led_pattern`,
  - `duty_q` ← `DUTY`.
- Consequence: pattern and duty changes never take effect mid-frame, so there is no glitch.

Blink:
- On each `frame_tick` with `BLINK_PERIOD` ≠ 0:
  - if `blink_cnt` == `BLINK_PERIOD`−1: clear `blink_cnt` and toggle `blink_phase`;
  - else increment `blink_cnt`.
- With `BLINK_PERIOD` = 0, `blink_phase` holds at 1.
- The blink counters run regardless of `blink_en`.

Output, per bit i:
- `lit[i]` = `enable` & `pattern_q[i]` & (`pwm_cnt` < `duty_q`) & (!`blink_en` | `blink_phase`).
- `led_out[i]` ← `lit[i]` ^ `invert`, registered.

Duty boundary cases:
- `duty_q` = 0: always off.
- `duty_q` = 255: always on, with no off-cycle, because `pwm_cnt` never reaches 255.

## Timing
Reset values:
- `led_out` = 0.
- `pwm_cnt` = 0, `blink_cnt` = 0, `blink_phase` = 1.
- `pattern_q` = 0, `duty_q` = 0xFF.
- Consequence: LEDs stay dark until the first `frame_tick` latches a pattern, which happens 255 cycles after reset release.

Latencies:
- `lit` → `led_out`: 1 cycle.
- `led_pattern` change → pin: visible from the second cycle of the next frame (latch at cnt 254, then `pwm_cnt` = 0, then `led_out` registered).
- `CTRL` write → pin: 2 cycles (register write, then output register).

Simultaneous events:
- `BLINK_PERIOD` write coinciding with `frame_tick`: the write wins; the counter clears and the phase is set to 1.
- `DUTY` write coinciding with `frame_tick`: `duty_q` takes the new value.

Reads and reset:
- `readdata` is valid in the same cycle as `address`/`chipselect`; reads have no side effects.
- Reset asserted mid-frame clears all state immediately, asynchronously; `led_out` goes to 0 even when `invert` was set.

## Structure
- Package `hps_led_pkg`:
  - register address constants `ADDR_CTRL`/`ADDR_DUTY`/`ADDR_PERIOD`/`ADDR_STATUS`,
  - CTRL bit indices,
  - reset values,
  - `PWM_MAX` = 254.
- Sub-module `hps_led_timebase`: `pwm_cnt`, `frame_tick`, `blink_cnt`, `blink_phase`, and the period-write clear input.
- Top level: register file, shadow/latch registers, and the output logic.

## Test plan
1. Reset, then idle 300 cycles with `led_pattern` = 0x7F.
   - `led_out` = 0 for 256 cycles after reset release, then 0x7F continuously (`DUTY` = 0xFF).
   - `CTRL` reads 0x1, `DUTY` reads 0xFF.
2. Write `DUTY` = 0x80, `led_pattern` = 0x01.
   - From the next frame on, `led_out[0]` is high exactly 128 of every 255 cycles.
   - Bits 6..1 stay 0.
   - `DUTY` = 0 gives a constant 0.
3. Write `BLINK_PERIOD` = 2 and `CTRL` = 0x3.
   - LEDs are on for 510 cycles, then off for 510 cycles, repeating.
   - `STATUS` bit0 tracks the on/off phase.
4. Change `led_pattern` 0x55 → 0x2A while `pwm_cnt` = 100.
   - `led_out` holds 0x55 until the frame ends, then shows 0x2A from the second cycle of the next frame.
5. Write `CTRL` = 0x5 (invert) with `led_pattern` = 0x0F.
   - `led_out` = 0x70 two cycles after the write.
   - Assert `reset_n` mid-frame: `led_out` = 0 immediately.
6. Write addr 3 with 0xFFFFFFFF.
   - No register changes.
   - `STATUS` readback shows `pwm_cnt` advancing.

Source files
------------

// File: rtl/hps_led_pkg.sv
// Shared constants for the HPS LED output stage: register map, CTRL bit
// layout, reset values and the PWM frame length helper.
package hps_led_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_INVERT   = 2;
  localparam int CTRL_W        = 3;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_PWM_LSB   = 8;

  typedef struct packed {
    logic invert;
    logic blink_en;
    logic enable;
  } ctrl_t;

  localparam logic [CTRL_W-1:0] CTRL_RESET   = 3'b001;
  localparam logic [7:0]        DUTY_RESET   = 8'hFF;
  localparam int                PERIOD_RESET = 0;

  // The frame is 2^w-1 cycles long, so the counter tops out one below that.
  function automatic int unsigned pwm_max_for(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

  localparam int PWM_MAX = pwm_max_for(8);

endpackage

// File: rtl/hps_led_timebase.sv
// PWM frame counter and blink phase generator; everything else in the LED
// driver is paced by the frame_tick produced here.
module hps_led_timebase
  import hps_led_pkg::*;
#(
  parameter int PWM_W   = 8,
  parameter int BLINK_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BLINK_W-1:0] period_i,
  input  logic               period_wr_i,
  output logic [PWM_W-1:0]   pwm_cnt_o,
  output logic               frame_tick_o,
  output logic               blink_phase_o
);

  localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'(pwm_max_for(PWM_W));

  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               frame_tick;

  assign frame_tick = (pwm_cnt_q == CNT_MAX);

  always_comb begin
    pwm_cnt_d     = frame_tick ? '0 : pwm_cnt_q + PWM_W'(1);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    // A period write restarts the blink cycle even if it lands on a frame tick.
    if (period_wr_i) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (frame_tick && (period_i != '0)) begin
      if (blink_cnt_q == period_i - BLINK_W'(1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign pwm_cnt_o     = pwm_cnt_q;
  assign frame_tick_o  = frame_tick;
  assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/hps_led_driver.sv
// LED pin driver between the HPS LED PIO and the board: frame-synchronous
// pattern latch, global PWM brightness, blinking and polarity inversion.
module hps_led_driver
  import hps_led_pkg::*;
#(
  parameter int LED_W   = 7,
  parameter int PWM_W   = 8,
  parameter int BLINK_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LED_W-1:0] led_pattern,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led_out
);

  ctrl_t              ctrl_q, ctrl_d;
  logic [PWM_W-1:0]   duty_shadow_q, duty_shadow_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic [BLINK_W-1:0] period_q, period_d;
  logic [LED_W-1:0]   pattern_q, pattern_d;
  logic [LED_W-1:0]   led_out_q, led_out_d;
  logic [LED_W-1:0]   lit;

  logic               wr_en, wr_ctrl, wr_duty, wr_period;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               frame_tick;
  logic               blink_phase;
  logic               pwm_on, blink_on;
  logic               unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_duty   = wr_en && (address == ADDR_DUTY);
  assign wr_period = wr_en && (address == ADDR_PERIOD);
  assign unused_wdata = ^writedata;

  hps_led_timebase #(
    .PWM_W   (PWM_W),
    .BLINK_W (BLINK_W)
  ) u_timebase (
    .clk           (clk),
    .reset_n       (reset_n),
    .period_i      (period_q),
    .period_wr_i   (wr_period),
    .pwm_cnt_o     (pwm_cnt),
    .frame_tick_o  (frame_tick),
    .blink_phase_o (blink_phase)
  );

  // duty_d samples the shadow's next value, so a DUTY write on the frame
  // tick is applied immediately rather than one frame late.
  always_comb begin
    ctrl_d        = wr_ctrl   ? ctrl_t'(writedata[CTRL_W-1:0]) : ctrl_q;
    duty_shadow_d = wr_duty   ? writedata[PWM_W-1:0]           : duty_shadow_q;
    period_d      = wr_period ? writedata[BLINK_W-1:0]         : period_q;
    pattern_d     = frame_tick ? led_pattern   : pattern_q;
    duty_d        = frame_tick ? duty_shadow_d : duty_q;
  end

  assign pwm_on   = (pwm_cnt < duty_q);
  assign blink_on = ~ctrl_q.blink_en | blink_phase;

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_lit
    assign lit[gi] = ctrl_q.enable & pattern_q[gi] & pwm_on & blink_on;
  end

  assign led_out_d = lit ^ {LED_W{ctrl_q.invert}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= ctrl_t'(CTRL_RESET);
      duty_shadow_q <= {PWM_W{1'b1}};
      duty_q        <= {PWM_W{1'b1}};
      period_q      <= BLINK_W'(PERIOD_RESET);
      pattern_q     <= '0;
      led_out_q     <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_shadow_q <= duty_shadow_d;
      duty_q        <= duty_d;
      period_q      <= period_d;
      pattern_q     <= pattern_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[CTRL_W-1:0]  = ctrl_q;
      ADDR_DUTY:   readdata[PWM_W-1:0]   = duty_shadow_q;
      ADDR_PERIOD: readdata[BLINK_W-1:0] = period_q;
      ADDR_STATUS: begin
        readdata[STATUS_PHASE_BIT]            = blink_phase;
        readdata[STATUS_PWM_LSB +: PWM_W]     = pwm_cnt;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hps_led_driver.sv
// Self-checking bench for hps_led_driver: a frame/arithmetic reference model
// plus directed scenarios and a randomized register/pattern soak.
module tb_hps_led_driver;

  logic        clk;
  logic        reset_n;
  logic [6:0]  led_pattern;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  led_out;

  int total = 0;
  int bad   = 0;

  hps_led_driver #(.LED_W(7), .PWM_W(8), .BLINK_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .led_pattern (led_pattern),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .led_out     (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time since reset, frames since the last period write.
  logic [2:0]  m_ctrl;
  logic [7:0]  m_duty_sh;
  logic [7:0]  m_duty;
  logic [15:0] m_period;
  logic [6:0]  m_pattern;
  int          m_t;
  int          m_frames;
  logic [6:0]  exp_led;

  function automatic logic m_phase();
    if (m_period == 16'd0) return 1'b1;
    return ((m_frames / int'(m_period)) % 2) == 0;
  endfunction

  function automatic logic [7:0] m_pwm();
    return 8'(m_t % 255);
  endfunction

  initial begin : model
    int         pwm;
    logic       wr;
    logic [6:0] lit;
    m_ctrl = 3'b001; m_duty_sh = 8'hFF; m_duty = 8'hFF; m_period = 16'd0;
    m_pattern = 7'd0; m_t = 0; m_frames = 0; exp_led = 7'd0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_ctrl = 3'b001; m_duty_sh = 8'hFF; m_duty = 8'hFF; m_period = 16'd0;
        m_pattern = 7'd0; m_t = 0; m_frames = 0; exp_led = 7'd0;
      end else begin
        pwm = m_t % 255;
        wr  = chipselect && !write_n;
        lit = 7'd0;
        if (m_ctrl[0] && (pwm < int'(m_duty)) && (!m_ctrl[1] || m_phase()))
          lit = m_pattern;
        exp_led = lit ^ {7{m_ctrl[2]}};
        if (pwm == 254) begin
          m_pattern = led_pattern;
          m_duty    = (wr && address == 2'd1) ? writedata[7:0] : m_duty_sh;
          m_frames++;
        end
        if (wr) begin
          case (address)
            2'd0: m_ctrl    = writedata[2:0];
            2'd1: m_duty_sh = writedata[7:0];
            2'd2: begin m_period = writedata[15:0]; m_frames = 0; end
            default: ;
          endcase
        end
        m_t++;
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    $display("write addr=%0d data=%h t=%0t", a, d, $time);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0]  exp_c;
    logic [31:0] r;
    led_pattern = 7'h7F;
    repeat (3) @(negedge clk);
    total++;
    if (led_out !== 7'd0) begin bad++; $display("FAIL reset_hold got=%h want=00", led_out); end
    reset_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      exp_c = (n <= 255) ? 7'h00 : 7'h7F;
      total++;
      if (led_out !== exp_c) begin bad++; $display("FAIL reset_idle n=%0d got=%h want=%h", n, led_out, exp_c); end
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL reset_model n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    bus_read(2'd0, r);
    total++;
    if (r !== 32'h1) begin bad++; $display("FAIL reset_ctrl got=%h want=00000001", r); end
    bus_read(2'd1, r);
    total++;
    if (r !== 32'hFF) begin bad++; $display("FAIL reset_duty got=%h want=000000ff", r); end
    bus_read(2'd2, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_period got=%h want=00000000", r); end
    $display("test_reset done");
  endtask

  task automatic test_pwm_duty();
    int hi;
    @(negedge clk);
    led_pattern = 7'h01;
    bus_write(2'd1, 32'h80);
    hi = 0;
    for (int n = 1; n <= 765; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL pwm80_model n=%0d got=%h want=%h", n, led_out, exp_led); end
      if (n > 510) begin
        if (led_out[0] === 1'b1) hi++;
        total++;
        if (led_out[6:1] !== 6'd0) begin bad++; $display("FAIL pwm80_upper n=%0d got=%h want=00", n, led_out[6:1]); end
      end
    end
    total++;
    if (hi != 128) begin bad++; $display("FAIL pwm80_ontime got=%0d want=128", hi); end
    bus_write(2'd1, 32'h0);
    for (int n = 1; n <= 765; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL pwm0_model n=%0d got=%h want=%h", n, led_out, exp_led); end
      if (n > 510) begin
        total++;
        if (led_out !== 7'd0) begin bad++; $display("FAIL pwm0_dark n=%0d got=%h want=00", n, led_out); end
      end
    end
    $display("test_pwm_duty done high_cycles=%0d", hi);
  endtask

  task automatic test_blink();
    logic [6:0]  prev;
    logic [31:0] s;
    int          run_len, runs_checked;
    logic        started;
    led_pattern = 7'h7F;
    bus_write(2'd1, 32'hFF);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h3);
    prev = 7'd0; run_len = 0; runs_checked = 0; started = 1'b0;
    for (int n = 1; n <= 3600; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL blink_model n=%0d got=%h want=%h", n, led_out, exp_led); end
      if (n == 1100) begin
        prev = led_out; run_len = 1;
      end else if (n > 1100) begin
        total++;
        if (led_out !== 7'h00 && led_out !== 7'h7F) begin bad++; $display("FAIL blink_level n=%0d got=%h want=00/7f", n, led_out); end
        if (led_out !== prev) begin
          if (started) begin
            runs_checked++;
            total++;
            if (run_len != 510) begin bad++; $display("FAIL blink_run len got=%0d want=510", run_len); end
          end
          started = 1'b1; run_len = 1; prev = led_out;
        end else begin
          run_len++;
        end
      end
      if (n % 97 == 0) begin
        bus_read(2'd3, s);
        total++;
        if (s[0] !== m_phase() || s[15:8] !== m_pwm()) begin
          bad++; $display("FAIL blink_status n=%0d got=%h want_phase=%0d want_pwm=%0d", n, s, m_phase(), m_pwm());
        end
      end
    end
    total++;
    if (runs_checked < 3) begin bad++; $display("FAIL blink_runs got=%0d want>=3", runs_checked); end
    $display("test_blink done runs=%0d", runs_checked);
  endtask

  task automatic test_pattern_change();
    logic [31:0] s;
    logic        found;
    logic [6:0]  exp_c;
    bus_write(2'd0, 32'h1);
    bus_write(2'd2, 32'h0);
    led_pattern = 7'h55;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL patt_pre n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      bus_read(2'd3, s);
      if (s[15:8] == 8'd100) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL patt_wait100 got=timeout want=pwm_cnt 100"); end
    led_pattern = 7'h2A;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      exp_c = (n <= 155) ? 7'h55 : 7'h2A;
      total++;
      if (led_out !== exp_c) begin bad++; $display("FAIL patt_switch n=%0d got=%h want=%h", n, led_out, exp_c); end
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL patt_model n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    $display("test_pattern_change done");
  endtask

  task automatic test_invert_reset();
    logic [31:0] r;
    logic [6:0]  exp_c;
    led_pattern = 7'h0F;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL inv_pre n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    bus_write(2'd0, 32'h5);
    total++;
    if (led_out !== 7'h0F) begin bad++; $display("FAIL inv_cycle1 got=%h want=0f", led_out); end
    @(negedge clk);
    total++;
    if (led_out !== 7'h70) begin bad++; $display("FAIL inv_cycle2 got=%h want=70", led_out); end
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== 7'h70 || led_out !== exp_led) begin bad++; $display("FAIL inv_hold n=%0d got=%h want=70", n, led_out); end
    end
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (led_out !== 7'h00) begin bad++; $display("FAIL inv_async_reset got=%h want=00", led_out); end
    bus_read(2'd0, r);
    total++;
    if (r !== 32'h1) begin bad++; $display("FAIL inv_reset_ctrl got=%h want=00000001", r); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      exp_c = (n <= 255) ? 7'h00 : 7'h0F;
      total++;
      if (led_out !== exp_c) begin bad++; $display("FAIL inv_post n=%0d got=%h want=%h", n, led_out, exp_c); end
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL inv_post_model n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    $display("test_invert_reset done");
  endtask

  task automatic test_status_write();
    logic [31:0] r, s1, s2;
    logic [7:0]  want_pwm;
    bus_write(2'd2, 32'h3);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd0, r);
    total++;
    if (r !== {29'd0, m_ctrl} || r !== 32'h1) begin bad++; $display("FAIL stw_ctrl got=%h want=00000001", r); end
    bus_read(2'd1, r);
    total++;
    if (r !== {24'd0, m_duty_sh}) begin bad++; $display("FAIL stw_duty got=%h want=%h", r, {24'd0, m_duty_sh}); end
    bus_read(2'd2, r);
    total++;
    if (r !== 32'h3) begin bad++; $display("FAIL stw_period got=%h want=00000003", r); end
    bus_read(2'd3, s1);
    total++;
    if (s1 !== {16'd0, m_pwm(), 7'd0, m_phase()}) begin
      bad++; $display("FAIL stw_status1 got=%h want=%h", s1, {16'd0, m_pwm(), 7'd0, m_phase()});
    end
    want_pwm = 8'((int'(m_pwm()) + 5) % 255);
    repeat (5) @(negedge clk);
    bus_read(2'd3, s2);
    total++;
    if (s2[15:8] !== want_pwm) begin bad++; $display("FAIL stw_advance got=%0d want=%0d", s2[15:8], want_pwm); end
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL stw_model n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    $display("test_status_write done");
  endtask

  task automatic test_boundary();
    logic [31:0] s;
    logic        found;
    logic [6:0]  exp_c;
    bus_write(2'd0, 32'h1);
    bus_write(2'd2, 32'h0);
    bus_write(2'd1, 32'hFF);
    led_pattern = 7'h7F;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL bnd_pre n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      bus_read(2'd3, s);
      if (s[15:8] == 8'd254) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL bnd_wait254 got=timeout want=pwm_cnt 254"); end
    bus_write(2'd1, 32'h0);
    total++;
    if (led_out !== 7'h7F) begin bad++; $display("FAIL bnd_duty_last got=%h want=7f", led_out); end
    for (int n = 2; n <= 256; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== 7'h00 || led_out !== exp_led) begin bad++; $display("FAIL bnd_duty_tick n=%0d got=%h want=00", n, led_out); end
    end
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'h3);
    bus_write(2'd2, 32'h1);
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL bnd_blink_pre n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      bus_read(2'd3, s);
      if (s[15:8] == 8'd254) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL bnd_wait254b got=timeout want=pwm_cnt 254"); end
    bus_write(2'd2, 32'h1);
    for (int n = 2; n <= 511; n++) begin
      @(negedge clk);
      exp_c = (n <= 256) ? 7'h7F : 7'h00;
      total++;
      if (led_out !== exp_c) begin bad++; $display("FAIL bnd_period_tick n=%0d got=%h want=%h", n, led_out, exp_c); end
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL bnd_period_model n=%0d got=%h want=%h", n, led_out, exp_led); end
    end
    $display("test_boundary done");
  endtask

  task automatic test_random();
    logic [1:0]  a;
    logic [31:0] r, want;
    int          nwr;
    nwr = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      total++;
      if (led_out !== exp_led) begin bad++; $display("FAIL rand_led c=%0d got=%h want=%h", c, led_out, exp_led); end
      if ($urandom_range(0, 49) == 0) led_pattern = 7'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        a = 2'($urandom_range(0, 3));
        case (a)
          2'd0:    want = {29'd0, m_ctrl};
          2'd1:    want = {24'd0, m_duty_sh};
          2'd2:    want = {16'd0, m_period};
          default: want = {16'd0, m_pwm(), 7'd0, m_phase()};
        endcase
        bus_read(a, r);
        total++;
        if (r !== want) begin bad++; $display("FAIL rand_read addr=%0d got=%h want=%h", a, r, want); end
      end
      if ($urandom_range(0, 19) == 0) begin
        a = 2'($urandom_range(0, 3));
        address = a;
        writedata = (a == 2'd2) ? (($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3))) : $urandom;
        chipselect = 1'b1; write_n = 1'b0;
        nwr++;
        $display("rand write addr=%0d data=%h", a, writedata);
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("test_random done writes=%0d", nwr);
  endtask

  initial begin
    reset_n = 1'b1; led_pattern = 7'd0; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    #2 reset_n = 1'b0;
    test_reset();
    test_pwm_duty();
    test_blink();
    test_pattern_change();
    test_invert_reset();
    test_status_write();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
